// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_reg                                               |
// | Description : Parametrised pipeline register with a valid/ready handshake  |
// |               and a 2-entry skid buffer. o_ready comes straight from a     |
// |               flop, so downstream backpressure never reaches upstream      |
// |               through combinational logic. A synchronous flush inserts a   |
// |               bubble, and o_data shows BUBBLE_VALUE whenever no valid      |
// |               payload is held.                                             |
// |               Optional macro PIPE_STAGE_REG_STALL_CNT_EN adds o_stall_cnt, |
// |               a 16-bit saturating count of stalled output cycles.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_stage_reg #(
  parameter int unsigned      WIDTH        = 96,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = {64'h0, 32'h00000013}
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
  ,
  output logic [15:0]      o_stall_cnt
`endif
);

  // The main entry drives the outputs. The skid entry holds one extra payload
  // that was accepted while the output was stalled.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_main_v;
  logic             r_skid_v;
  logic [WIDTH-1:0] r_main_d;
  logic [WIDTH-1:0] r_skid_d;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_main_ld_in;
  logic             w_main_ld_skid;
  logic             w_skid_ld;

  // The handshakes are qualified only by flopped flags.
  assign w_in_xfer  = i_valid & r_skid_v ? 1'b0 : i_valid;
  assign w_out_xfer = r_main_v & i_ready;

  // Each output is a direct flop value or a mux selected by a flop.
  assign o_valid = r_main_v;
  assign o_ready = ~r_skid_v;
  assign o_data  = r_main_v ? r_main_d : BUBBLE_VALUE;

  // Next-state and load-enable decode. Flush overrides every transition.
  always_comb begin
    w_state_nxt    = r_state;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_main_ld_in = 1'b1;
          w_state_nxt  = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_in_xfer && w_out_xfer) begin
          w_main_ld_in = 1'b1;
        end else if (w_in_xfer) begin
          w_skid_ld   = 1'b1;
          w_state_nxt = ST_SKID;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (w_out_xfer) begin
          w_main_ld_skid = 1'b1;
          w_state_nxt    = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
    if (i_flush) begin
      w_state_nxt    = ST_EMPTY;
      w_main_ld_in   = 1'b0;
      w_main_ld_skid = 1'b0;
      w_skid_ld      = 1'b0;
    end
  end

  // State register. The valid flags are registered copies of the next-state
  // decode, so o_valid and o_ready have no logic after the flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_EMPTY;
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_main_v <= (w_state_nxt != ST_EMPTY);
      r_skid_v <= (w_state_nxt == ST_SKID);
    end
  end

  // Payload storage. A flushed main entry is parked at the bubble encoding.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_main_d <= BUBBLE_VALUE;
      r_skid_d <= '0;
    end else begin
      if (i_flush) begin
        r_main_d <= BUBBLE_VALUE;
      end else if (w_main_ld_in) begin
        r_main_d <= i_data;
      end else if (w_main_ld_skid) begin
        r_main_d <= r_skid_d;
      end
      if (w_skid_ld) begin
        r_skid_d <= i_data;
      end
    end
  end

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
  localparam logic [15:0] c_STALL_MAX = 16'hFFFF;

  logic [15:0] r_stall_cnt;

  // Count cycles where a valid payload waits on downstream; saturates.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_flush) begin
      r_stall_cnt <= '0;
    end else if (r_main_v && !i_ready && (r_stall_cnt != c_STALL_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_stage_reg                                            |
// | Description : Self-checking bench for pipe_stage_reg. A queue-based model  |
// |               of the stage contents predicts the outputs every cycle.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_reg;

  localparam int          W      = 96;
  localparam logic [W-1:0] BUBBLE = {64'h0, 32'h00000013};

  logic         i_clk   = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_flush = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b0;
  logic [W-1:0] i_data  = '0;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] o_data;
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
  logic [15:0]  o_stall_cnt;
`endif

  pipe_stage_reg #(
    .WIDTH        (W),
    .BUBBLE_VALUE (BUBBLE)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data)
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    ,
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the stage is a FIFO of at most two payloads plus a stall counter.
  logic [W-1:0] q[$];
  int unsigned  m_cnt = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic check_outputs();
    logic [W-1:0] exp_d;
    if (q.size() > 0) exp_d = q[0];
    else              exp_d = BUBBLE;
    check("o_valid", {127'd0, o_valid}, {127'd0, q.size() > 0});
    check("o_ready", {127'd0, o_ready}, {127'd0, q.size() < 2});
    check("o_data",  {32'd0, o_data},   {32'd0, exp_d});
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    check("o_stall_cnt", {112'd0, o_stall_cnt}, {112'd0, m_cnt[15:0]});
`endif
  endtask

  // One clock: drive inputs at the falling edge, check, advance the model.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    bit exp_v;
    bit exp_rdy;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    i_flush = f;
    check_outputs();
    exp_v   = q.size() > 0;
    exp_rdy = q.size() < 2;
    @(posedge i_clk);
    if (f) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (exp_v && !r && m_cnt < 65535) m_cnt++;
      if (exp_v && r) void'(q.pop_front());
      if (v && exp_rdy) q.push_back(d);
    end
    @(negedge i_clk);
  endtask

  initial begin
    logic [W-1:0] a, b, c, d;
    logic         pend;
    logic [W-1:0] pd;
    logic         f;
    logic         r;
    bit           acc;

    // Reset and idle
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    q.delete();
    m_cnt = 0;
    check("rst_data_nop", {32'd0, o_data}, {32'd0, 64'h0, 32'h00000013});
    cycle(1'b0, rnd_data(), 1'b1, 1'b0);
    cycle(1'b0, rnd_data(), 1'b0, 1'b0);

    // Streaming with downstream always ready
    a = rnd_data(); b = rnd_data(); c = rnd_data();
    cycle(1'b1, a, 1'b1, 1'b0);
    cycle(1'b1, b, 1'b1, 1'b0);
    cycle(1'b1, c, 1'b1, 1'b0);
    check("stream_c", {32'd0, o_data}, {32'd0, c});
    repeat (2) cycle(1'b0, rnd_data(), 1'b1, 1'b0);

    // Backpressure: A main, B skid, C held upstream, then drain in order
    a = rnd_data(); b = rnd_data(); c = rnd_data();
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    check("bp_ready_low", {127'd0, o_ready}, 128'd0);
    cycle(1'b1, c, 1'b0, 1'b0);
    cycle(1'b1, c, 1'b1, 1'b0);
    cycle(1'b1, c, 1'b1, 1'b0);
    check("bp_c_out", {32'd0, o_data}, {32'd0, c});
    repeat (2) cycle(1'b0, rnd_data(), 1'b1, 1'b0);

    // Flush while both entries are full; D must be discarded
    a = rnd_data(); b = rnd_data(); d = rnd_data();
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    cycle(1'b1, d, 1'b0, 1'b1);
    check("flush_bubble", {32'd0, o_data}, {32'd0, BUBBLE});
    repeat (2) cycle(1'b0, rnd_data(), 1'b1, 1'b0);

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    // Stall counter: 5 stalls, flush clear, saturation
    cycle(1'b1, rnd_data(), 1'b0, 1'b0);
    repeat (5) cycle(1'b0, rnd_data(), 1'b0, 1'b0);
    check("stall_5", {112'd0, o_stall_cnt}, 128'd5);
    cycle(1'b0, rnd_data(), 1'b0, 1'b1);
    check("stall_flush", {112'd0, o_stall_cnt}, 128'd0);
    cycle(1'b1, rnd_data(), 1'b0, 1'b0);
    repeat (70000) cycle(1'b0, rnd_data(), 1'b0, 1'b0);
    check("stall_sat", {112'd0, o_stall_cnt}, 128'hFFFF);
    cycle(1'b0, rnd_data(), 1'b0, 1'b1);
`endif

    // Randomized traffic with an upstream that holds its payload until taken
    pend = 1'b0;
    pd   = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 1) == 1);
        pd   = rnd_data();
      end
      r   = ($urandom_range(0, 3) != 0);
      f   = ($urandom_range(0, 31) == 0);
      acc = pend && (q.size() < 2);
      cycle(pend, pd, r, f);
      if (acc) pend = 1'b0;
    end

    // Asynchronous reset in the middle of a cycle while holding a payload
    cycle(1'b1, rnd_data(), 1'b0, 1'b0);
    cycle(1'b0, rnd_data(), 1'b0, 1'b0);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_valid", {127'd0, o_valid}, 128'd0);
    check("arst_ready", {127'd0, o_ready}, 128'd1);
    check("arst_data",  {32'd0, o_data},   {32'd0, BUBBLE});
    q.delete();
    m_cnt = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cycle(1'b0, rnd_data(), 1'b1, 1'b0);
    cycle(1'b1, rnd_data(), 1'b1, 1'b0);
    cycle(1'b0, rnd_data(), 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic parametrised pipeline register for the CPU pipeline, replacing the fixed per-stage registers between pipeline stages (Q1/Q2 onward).
- Carries a WIDTH-bit packed payload.
- Full valid/ready handshake with a 2-entry skid buffer, so o_ready is registered and backpressure paths are cut.
- Synchronous flush inserts a bubble.
- The output carries BUBBLE_VALUE (an encoded NOP) whenever it holds no valid payload.

Parameters:
- WIDTH, 96, payload width in bits (insn 32 + pc 32 + pc_incr 32 for the Q1/Q2 stage).
- BUBBLE_VALUE, {64'h0, 32'h00000013}, payload driven on o_data when o_valid=0. Default is NOP in insn bits [31:0].

Ports:
- i_clk  input  1  clock, all state updates on its rising edge.
- i_rst_n  input  1  reset, asynchronous and active-low.
- i_flush  input  1  synchronous flush, kills all held entries.
- i_valid  input  1  upstream payload valid.
- o_ready  output  1  stage can accept a payload; registered.
- i_data  input  WIDTH  upstream payload.
- o_valid  output  1  downstream payload valid.
- i_ready  input  1  downstream accepts payload.
- o_data  output  WIDTH  payload to downstream.

Behaviour:
- Reset (async assert, sync release): o_valid=0, o_ready=1, o_data=BUBBLE_VALUE, both entries invalid, state EMPTY.
- Transfers:
  - in_xfer = i_valid & o_ready.
  - out_xfer = o_valid & i_ready.
- Storage:
  - main entry (main_v, main_d) drives the outputs.
  - skid entry (skid_v, skid_d) is used only under backpressure.
- Outputs:
  - o_valid = main_v.
  - o_data = main_v ? main_d : BUBBLE_VALUE.
  - o_ready = ~skid_v, taken from the flop directly with no combinational path from i_ready.
- States and transitions:
  - EMPTY (main_v=0, skid_v=0):
    - in_xfer -> main<=i_data, go to FULL.
    - otherwise stay.
  - FULL (main_v=1, skid_v=0):
    - in_xfer & out_xfer -> main<=i_data, stay FULL.
    - in_xfer only -> skid<=i_data, go to SKID.
    - out_xfer only -> go to EMPTY.
    - neither -> hold.
  - SKID (both valid, o_ready=0):
    - out_xfer -> main<=skid_d, skid_v<=0, go to FULL.
    - otherwise hold.
- Latency: 1 cycle from in_xfer to o_valid. Throughput: 1 payload/cycle when i_ready is held high.
- Ordering: strict FIFO. The skid entry is never presented before main.
- Flush (highest priority):
  - Next state EMPTY, main_v=0, skid_v=0, main_d<=BUBBLE_VALUE.
  - Any in_xfer in the same cycle is discarded.
  - out_xfer in the flush cycle still counts as a completed transfer for downstream.
  - o_ready=1 the cycle after a flush.
- i_valid while o_ready=0: no effect. Upstream must hold its payload.
- Payload data is never modified or truncated. Entries load i_data as-is, full WIDTH.
- Reset mid-transfer: all held entries are lost and outputs go immediately to reset values.
- Invariant: skid_v=1 implies main_v=1. Any other combination is a design error.

Optional Feature:
Macro PIPE_STAGE_REG_STALL_CNT_EN.
- Defined:
  - Adds port o_stall_cnt, output, 16 bits.
  - Saturating counter, increments each cycle that o_valid=1 and i_ready=0.
  - Holds at 16'hFFFF once saturated.
  - Cleared to 0 by reset or i_flush; flush takes priority over increment.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle, i_valid=0 -> o_valid=0, o_ready=1, o_data[31:0]=32'h00000013, other bits 0.
- Stream with i_ready=1: i_data=A,B,C on 3 consecutive cycles, i_valid=1 -> o_data A,B,C on cycles 1,2,3, o_valid=1, o_ready stays 1.
- Backpressure: load A, i_ready=0, then offer B -> B goes to skid, o_ready=0 next cycle, C held upstream. Then i_ready=1 -> outputs A, B, C in order with no loss or duplication.
- Flush while in SKID (A main, B skid) with i_valid=1, i_data=D -> next cycle o_valid=0, o_data=BUBBLE_VALUE, o_ready=1, D never appears.
- Async reset asserted mid-cycle while FULL -> o_valid drops to 0 and o_data=BUBBLE_VALUE before the next clock edge.
- With PIPE_STAGE_REG_STALL_CNT_EN defined:
  - Hold o_valid=1 and i_ready=0 for 5 cycles -> o_stall_cnt=5.
  - Flush -> o_stall_cnt=0.
  - Force 70000 stall cycles -> o_stall_cnt=16'hFFFF.
